i2c_phase_timer: RTL and testbench
==================================

Name: i2c_phase_timer

Overview:
Parametrised successor to the single-strobe I2C bit timer. It divides each I2C bit period into four quarter-bit phases and drives the SCL level. It honours slave clock stretching and counts bits within a byte/ACK frame. It sits between the I2C byte engine (which consumes the phase strobes to drive and sample SDA) and the SCL pad.

Parameters:
SIZE, 8, width of the quarter-period down-counter and of Ticks
NBITS, 9, bits per frame (8 data + ACK); BitCnt wraps after NBITS
CNTW, 4, width of BitCnt; must satisfy 2^CNTW >= NBITS
TOUT_W, 16, width of the stretch-timeout counter (used only with the optional feature)

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous, active-low reset
Ticks  input  SIZE  quarter-period reload value; one phase lasts Ticks+1 enabled cycles
Start  input  1  level; while high, the block holds at phase 0 with the counter at Ticks; on release, the block runs
Stop  input  1  level; pauses counting when not starting
Scl_i  input  1  synchronised SCL bus level (for stretch detection)
Tout  input  TOUT_W  stretch timeout in cycles (optional feature only)
Scl_o  output  1  SCL drive level (1 = release/high)
Phase  output  2  current quarter phase 0..3
PhaseTick  output  1  one-cycle pulse at each phase boundary
BitEnd  output  1  one-cycle pulse when phase 3 completes
FrameDone  output  1  one-cycle pulse when bit NBITS-1 completes
BitCnt  output  CNTW  index of the current bit in the frame
Count  output  SIZE  current counter value
Busy  output  1  high in RUN state
Stretching  output  1  high while the counter is frozen by a slave stretch
Timeout  output  1  sticky stretch timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE; Count=0, Phase=0, BitCnt=0, Scl_o=1, all pulses 0, Busy=0, Stretching=0, Timeout=0.
- States:
  - IDLE: Scl_o=1; the block leaves IDLE only when Start=1.
  - LOAD: entered from any state while Start=1. Count<=Ticks, Phase<=0, BitCnt<=0, Timeout<=0. The block stays in LOAD while Start=1.
  - RUN: entered on the first cycle with Start=0 after LOAD.
- Priority within each cycle: Start > Stop > stretch > count. When Start and Stop are both high, Start wins.
- RUN with Stop=1: all registers hold and no pulses are generated. Busy stays 1.
- Stretch condition: Phase==2 and Scl_i==0 while Scl_o==1. Under this condition Count holds, Stretching=1, and no strobe fires.
- Counting: an enabled cycle is one in RUN with Stop=0 and no stretch.
  - On an enabled cycle with Count!=0: Count decrements by 1.
  - On an enabled cycle with Count==0: Count<=Ticks (sampled now), Phase<=Phase+1 (3 wraps to 0), and PhaseTick=1 on the next cycle (registered).
  - Ticks=0 gives a PhaseTick on every enabled cycle.
- Scl_o is registered and equals Phase[1]: phases 0 and 1 drive low, phases 2 and 3 release.
- BitEnd is registered in the same cycle as the PhaseTick for the 3->0 wrap. On that wrap, BitCnt increments; at NBITS-1 it wraps to 0 and FrameDone pulses together with BitEnd.
- Ticks changes mid-phase take effect only at the next reload.
- Reset asserted mid-operation aborts immediately to reset values; no partial pulses.
- Start asserted mid-bit aborts the frame: BitCnt=0 and no BitEnd or FrameDone is emitted.

Optional Feature:
- Macro I2C_PHASE_TIMER_STRETCH_TIMEOUT_EN.
- Defined:
  - A TOUT_W counter clears on each non-stretch cycle and increments while Stretching=1.
  - When it reaches Tout, Timeout<=1 (sticky). The block then behaves as if Stop=1 until Start is asserted.
  - Tout=0 disables the timeout.
- Undefined: no timeout counter is instantiated, Timeout is tied 0, stretching may last indefinitely, and the Tout port is present but ignored.

Test Plan:
- Ticks=3, pulse Start for 2 cycles, Scl_i=1 -> PhaseTick every 4 cycles; Scl_o low for 8 cycles, then high for 8; BitEnd every 16 cycles; FrameDone on the 9th BitEnd; BitCnt 0..8 then 0.
- Ticks=0 -> PhaseTick every cycle; full bit takes 4 cycles; Scl_o toggles every 2 cycles.
- RUN, Ticks=5, Stop high for 10 cycles at Count=2 -> Count holds 2, no pulses; resumes at 2 and the phase completes 3 cycles after Stop falls.
- Phase 2 with Scl_i held 0 for 20 cycles -> Stretching=1 for 20 cycles, Count frozen, phase extended by 20 cycles; no Timeout without the macro; with the macro and Tout=8, Timeout=1 after 8 cycles, the block stays frozen until Start, and Start clears Timeout.
- Start and Stop asserted together mid-bit (BitCnt=4) -> LOAD wins: Count=Ticks, Phase=0, BitCnt=0, no BitEnd.
- Rst_n pulsed low mid-phase 3 -> all outputs at reset values asynchronously (Scl_o=1, Busy=0); the block stays IDLE until Start.

Source files
------------

// File: rtl/i2c_phase_timer.sv
// Quarter-bit phase timer for an I2C master: drives SCL, honours slave clock
// stretching and counts bits per frame. Optional macro: I2C_PHASE_TIMER_STRETCH_TIMEOUT_EN.
module i2c_phase_timer #(
    parameter int SIZE   = 8,
    parameter int NBITS  = 9,
    parameter int CNTW   = 4,
    parameter int TOUT_W = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [SIZE-1:0]   Ticks,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Scl_i,
    input  logic [TOUT_W-1:0] Tout,
    output logic              Scl_o,
    output logic [1:0]        Phase,
    output logic              PhaseTick,
    output logic              BitEnd,
    output logic              FrameDone,
    output logic [CNTW-1:0]   BitCnt,
    output logic [SIZE-1:0]   Count,
    output logic              Busy,
    output logic              Stretching,
    output logic              Timeout
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state;
    logic [SIZE-1:0] count;
    logic [1:0]      phase;
    logic [1:0]      next_phase;
    logic [CNTW-1:0] bit_cnt;
    logic            scl_q;
    logic            phase_tick;
    logic            bit_end;
    logic            frame_done;
    logic            busy;
    logic            halted;
    logic            stretch_cond;
    logic            stretch_now;
    logic            enabled;

`ifdef I2C_PHASE_TIMER_STRETCH_TIMEOUT_EN
    logic [TOUT_W-1:0] tout_cnt;
    logic [TOUT_W:0]   tout_next;
    logic              timeout_q;

    assign tout_next = {1'b0, tout_cnt} + (TOUT_W+1)'(1);
    assign halted    = timeout_q;
    assign Timeout   = timeout_q;

    // Stretch watchdog; once it fires the timer is frozen until the next Start.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tout_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (Start) begin
            tout_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (stretch_now) begin
            if (!tout_next[TOUT_W])
                tout_cnt <= tout_next[TOUT_W-1:0];
            if (Tout != '0 && tout_next == {1'b0, Tout})
                timeout_q <= 1'b1;
        end else begin
            tout_cnt <= '0;
        end
    end
`else
    logic unused_tout;

    assign unused_tout = ^Tout;
    assign halted      = 1'b0;
    assign Timeout     = 1'b0;
`endif

    // A slave holding SCL low while we release it during phase 2 freezes the count.
    assign stretch_cond = (phase == 2'd2) && !Scl_i && scl_q;
    assign stretch_now  = (state == RUN) && !Start && !Stop && !halted && stretch_cond;
    assign enabled      = (state == RUN) && !Start && !Stop && !halted && !stretch_cond;
    assign next_phase   = phase + 2'd1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            count      <= '0;
            phase      <= 2'd0;
            bit_cnt    <= '0;
            scl_q      <= 1'b1;
            phase_tick <= 1'b0;
            bit_end    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            phase_tick <= 1'b0;
            bit_end    <= 1'b0;
            frame_done <= 1'b0;
            if (Start) begin
                state   <= LOAD;
                count   <= Ticks;
                phase   <= 2'd0;
                bit_cnt <= '0;
                scl_q   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                    RUN: begin
                        if (enabled) begin
                            if (count != '0) begin
                                count <= count - SIZE'(1);
                            end else begin
                                count      <= Ticks;
                                phase      <= next_phase;
                                scl_q      <= next_phase[1];
                                phase_tick <= 1'b1;
                                if (phase == 2'd3) begin
                                    bit_end <= 1'b1;
                                    if (bit_cnt == CNTW'(NBITS-1)) begin
                                        bit_cnt    <= '0;
                                        frame_done <= 1'b1;
                                    end else begin
                                        bit_cnt <= bit_cnt + CNTW'(1);
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Scl_o      = scl_q;
    assign Phase      = phase;
    assign PhaseTick  = phase_tick;
    assign BitEnd     = bit_end;
    assign FrameDone  = frame_done;
    assign BitCnt     = bit_cnt;
    assign Count      = count;
    assign Busy       = busy;
    assign Stretching = stretch_now;

endmodule

// File: tb/tb_i2c_phase_timer.sv
// Directed self-checking bench for i2c_phase_timer (default parameters).
`timescale 1ns/1ps
module tb_i2c_phase_timer;

    logic        Clk;
    logic        Rst_n;
    logic [7:0]  Ticks;
    logic        Start;
    logic        Stop;
    logic        Scl_i;
    logic [15:0] Tout;
    logic        Scl_o;
    logic [1:0]  Phase;
    logic        PhaseTick;
    logic        BitEnd;
    logic        FrameDone;
    logic [3:0]  BitCnt;
    logic [7:0]  Count;
    logic        Busy;
    logic        Stretching;
    logic        Timeout;

    int vectors     = 0;
    int miscompares = 0;

    i2c_phase_timer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Ticks(Ticks), .Start(Start), .Stop(Stop),
        .Scl_i(Scl_i), .Tout(Tout), .Scl_o(Scl_o), .Phase(Phase),
        .PhaseTick(PhaseTick), .BitEnd(BitEnd), .FrameDone(FrameDone),
        .BitCnt(BitCnt), .Count(Count), .Busy(Busy), .Stretching(Stretching),
        .Timeout(Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic scl);
        Start = start;
        Stop  = stop;
        Scl_i = scl;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Start held two cycles, then one cycle to enter RUN with Count=Ticks.
    task automatic startRun(input logic [7:0] t);
        Ticks = t;
        applyStimulus(1'b1, 1'b0, Scl_i);
        step(2);
        applyStimulus(1'b0, 1'b0, Scl_i);
        step(1);
    endtask

    // Free-running expectations after k enabled cycles from RUN entry.
    task automatic checkRun(input int t, input int nCycles);
        int q, r, ph, bits;
        logic tick, be;
        for (int k = 1; k <= nCycles; k++) begin
            step(1);
            q    = k / (t + 1);
            r    = k % (t + 1);
            ph   = q % 4;
            bits = (q / 4) % 9;
            tick = (r == 0);
            be   = tick && (ph == 0);
            checkOutput("run_count", Count, t - r);
            checkOutput("run_phase", Phase, ph);
            checkOutput("run_tick", PhaseTick, tick);
            checkOutput("run_bitend", BitEnd, be);
            checkOutput("run_bitcnt", BitCnt, bits);
            checkOutput("run_frame", FrameDone, be && (bits == 0));
            checkOutput("run_scl", Scl_o, ph[1]);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        Ticks = 8'd3;
        Tout  = 16'd0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        #12;
        checkOutput("rst_count", Count, 0);
        checkOutput("rst_phase", Phase, 0);
        checkOutput("rst_bitcnt", BitCnt, 0);
        checkOutput("rst_scl", Scl_o, 1);
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_pulses", {PhaseTick, BitEnd, FrameDone}, 0);
        checkOutput("rst_stretch", Stretching, 0);
        checkOutput("rst_timeout", Timeout, 0);
        Rst_n = 1'b1;
        step(3);
        checkOutput("idle_busy", Busy, 0);
        checkOutput("idle_scl", Scl_o, 1);

        // Ticks=3: full frame of 9 bits, 16 cycles each
        startRun(8'd3);
        checkOutput("t3_busy", Busy, 1);
        checkOutput("t3_count0", Count, 3);
        checkOutput("t3_scl0", Scl_o, 0);
        checkRun(3, 9 * 16 + 4);

        // Ticks=0: phase every cycle
        startRun(8'd0);
        checkOutput("t0_count0", Count, 0);
        checkRun(0, 40);

        // Stop pauses at Count=2 with Ticks=5
        startRun(8'd5);
        step(3);
        checkOutput("stop_pre", Count, 2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            checkOutput("stop_count", Count, 2);
            checkOutput("stop_tick", PhaseTick, 0);
            checkOutput("stop_busy", Busy, 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(2);
        checkOutput("resume_count", Count, 0);
        checkOutput("resume_notick", PhaseTick, 0);
        step(1);
        checkOutput("resume_tick", PhaseTick, 1);
        checkOutput("resume_phase", Phase, 1);
        checkOutput("resume_reload", Count, 5);

        // Ticks change mid-phase only applies at the next reload
        startRun(8'd3);
        step(1);
        Ticks = 8'd6;
        step(1);
        checkOutput("tchg_count1", Count, 1);
        step(2);
        checkOutput("tchg_reload", Count, 6);
        checkOutput("tchg_phase", Phase, 1);

        // Slave stretch in phase 2 for 20 cycles
        startRun(8'd3);
        step(8);
        checkOutput("str_phase", Phase, 2);
        checkOutput("str_scl", Scl_o, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("str_flag", Stretching, 1);
            step(1);
            checkOutput("str_count", Count, 3);
            checkOutput("str_tick", PhaseTick, 0);
        end
        checkOutput("str_timeout", Timeout, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("str_release", Stretching, 0);
        step(3);
        checkOutput("str_tail_count", Count, 0);
        checkOutput("str_tail_phase", Phase, 2);
        step(1);
        checkOutput("str_tail_tick", PhaseTick, 1);
        checkOutput("str_tail_phase3", Phase, 3);

`ifdef I2C_PHASE_TIMER_STRETCH_TIMEOUT_EN
        Tout = 16'd8;
        startRun(8'd3);
        step(8);
        applyStimulus(1'b0, 1'b0, 1'b0);
        step(7);
        checkOutput("tout_early", Timeout, 0);
        step(1);
        checkOutput("tout_set", Timeout, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(5);
        checkOutput("tout_frozen_cnt", Count, 3);
        checkOutput("tout_frozen_ph", Phase, 2);
        checkOutput("tout_sticky", Timeout, 1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        step(1);
        checkOutput("tout_clear", Timeout, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(1);
        Tout = 16'd0;
`endif

        // Start+Stop together just before a bit would end at BitCnt=4
        startRun(8'd3);
        step(79);
        checkOutput("abort_pre_bit", BitCnt, 4);
        checkOutput("abort_pre_ph", Phase, 3);
        checkOutput("abort_pre_cnt", Count, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        step(1);
        checkOutput("abort_count", Count, 3);
        checkOutput("abort_phase", Phase, 0);
        checkOutput("abort_bitcnt", BitCnt, 0);
        checkOutput("abort_bitend", BitEnd, 0);
        checkOutput("abort_busy", Busy, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(1);
        checkOutput("abort_run", Busy, 1);

        // Asynchronous reset in phase 3
        startRun(8'd3);
        step(13);
        checkOutput("ar_pre_phase", Phase, 3);
        Rst_n = 1'b0;
        #2;
        checkOutput("ar_scl", Scl_o, 1);
        checkOutput("ar_busy", Busy, 0);
        checkOutput("ar_count", Count, 0);
        checkOutput("ar_phase", Phase, 0);
        step(1);
        Rst_n = 1'b1;
        step(4);
        checkOutput("ar_idle_busy", Busy, 0);
        checkOutput("ar_idle_count", Count, 0);
        checkOutput("ar_idle_tick", PhaseTick, 0);
        startRun(8'd2);
        checkOutput("ar_restart", Busy, 1);
        checkOutput("ar_restart_cnt", Count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
